// File: rtl/draw_sequencer.sv
// Raster pixel-draw sequencer: walks a full screen or a sprite, issues linear ROM
// addresses, aligns the one-cycle ROM latency and drives clipped VGA plot requests.
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        fullScreen,
    input  logic [7:0]  xOrigin,
    input  logic [6:0]  yOrigin,
    input  logic [6:0]  memSelIn,
    input  logic        blackIn,
    input  logic [2:0]  romData,
    output logic [14:0] romAddr,
    output logic [6:0]  memorySel,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  color,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAW  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0]  SCR_LAST_COL  = 8'(SCREEN_W - 1);
    localparam logic [7:0]  SPR_LAST_COL  = 8'(SPRITE_W - 1);
    localparam logic [14:0] SCR_LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [14:0] SPR_LAST_ADDR = 15'(SPRITE_W * SPRITE_H - 1);
    localparam logic [8:0]  SCR_W_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0]  SCR_H_LIMIT   = 8'(SCREEN_H);

    logic [1:0]  state_r;
    logic [1:0]  nextState_s;
    logic [7:0]  col_r;
    logic [6:0]  row_r;
    logic [14:0] romAddr_r;
    logic        full_r;
    logic [7:0]  xOrg_r;
    logic [6:0]  yOrg_r;
    logic [6:0]  memSel_r;
    logic        black_r;
    logic [8:0]  sx_r;
    logic [7:0]  sy_r;
    logic        valid_r;
    logic [7:0]  lastCol_s;
    logic [14:0] lastAddr_s;
    logic        colWrap_s;
    logic        lastPix_s;
    logic        onScreen_s;

    // Geometry of the latched image kind: where a row ends and where the image ends.
    always_comb begin
        lastCol_s  = 8'd0;
        lastAddr_s = 15'd0;
        if (full_r) begin
            lastCol_s  = SCR_LAST_COL;
            lastAddr_s = SCR_LAST_ADDR;
        end else begin
            lastCol_s  = SPR_LAST_COL;
            lastAddr_s = SPR_LAST_ADDR;
        end
        colWrap_s = (col_r == lastCol_s);
        lastPix_s = (romAddr_r == lastAddr_s);
    end

    // Next-state decode; start is only honoured while idle, so requests never queue.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nextState_s = DRAW;
                end else begin
                    nextState_s = IDLE;
                end
            end
            DRAW: begin
                if (lastPix_s) begin
                    nextState_s = FLUSH;
                end else begin
                    nextState_s = DRAW;
                end
            end
            FLUSH:   nextState_s = DONE;
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Request parameters, captured once per accepted start and held until the next one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full_r   <= 1'b0;
            xOrg_r   <= 8'd0;
            yOrg_r   <= 7'd0;
            memSel_r <= 7'd0;
            black_r  <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            full_r   <= fullScreen;
            xOrg_r   <= fullScreen ? 8'd0 : xOrigin;
            yOrg_r   <= fullScreen ? 7'd0 : yOrigin;
            memSel_r <= memSelIn;
            black_r  <= blackIn;
        end
    end

    // Raster walk: column/row counters and the linear ROM address advance together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_r     <= 8'd0;
            row_r     <= 7'd0;
            romAddr_r <= 15'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        col_r     <= 8'd0;
                        row_r     <= 7'd0;
                        romAddr_r <= 15'd0;
                    end
                end
                DRAW: begin
                    // The final address is held rather than stepped, so it never wraps.
                    if (!lastPix_s) begin
                        romAddr_r <= romAddr_r + 15'd1;
                        if (colWrap_s) begin
                            col_r <= 8'd0;
                            row_r <= row_r + 7'd1;
                        end else begin
                            col_r <= col_r + 8'd1;
                        end
                    end
                end
                default: begin
                    col_r <= col_r;
                end
            endcase
        end
    end

    // Stage-1 screen coordinates, aligned with the ROM word that arrives next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sx_r    <= 9'd0;
            sy_r    <= 8'd0;
            valid_r <= 1'b0;
        end else if (state_r == DRAW) begin
            sx_r    <= {1'b0, xOrg_r} + {1'b0, col_r};
            sy_r    <= {1'b0, yOrg_r} + {1'b0, row_r};
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // VGA side: clip off-screen pixels and substitute black when requested.
    always_comb begin
        onScreen_s = (sx_r < SCR_W_LIMIT) && (sy_r < SCR_H_LIMIT);
        plot       = valid_r && onScreen_s;
        if (valid_r && !black_r) begin
            color = romData;
        end else begin
            color = 3'b000;
        end
    end

    assign x         = sx_r[7:0];
    assign y         = sy_r[6:0];
    assign romAddr   = romAddr_r;
    assign memorySel = memSel_r;
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);

endmodule
